// File: rtl/button_conditioner.sv
// Four-channel pushbutton conditioner: 2-flop synchronizer, per-button debounce FSM, level/press/release outputs.
// Optional auto-repeat on bits 0/1 when the BTN_REPEAT_EN macro is defined.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] btn_n_i,
  output logic [3:0] btn_level_o,
  output logic [3:0] btn_press_o,
  output logic [3:0] btn_release_o
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048576 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_conditioner: illegal parameter value");
  end

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The entry sample already counts as the first stable sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_CHK_PRESS,
    ST_PRESSED,
    ST_CHK_RELEASE
  } state_e;

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       s;
  state_e           state_q [4];
  state_e           state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       level_q, level_d;
  logic [3:0]       press_q, press_d;
  logic [3:0]       release_q, release_d;

`ifdef BTN_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [3:0]       REPEAT_MASK     = 4'b0011;

  logic [RPT_W-1:0] rpt_cnt_q [4];
  logic [RPT_W-1:0] rpt_cnt_d [4];
  logic [3:0]       rpt_first_q, rpt_first_d;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    sync1_d   = btn_n_i;
    sync2_d   = sync1_q;
    s         = ~sync2_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
`ifdef BTN_REPEAT_EN
    rpt_first_d = '1;
`endif
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      case (state_q[i])
        ST_RELEASED: if (s[i]) state_d[i] = ST_CHK_PRESS;
        ST_CHK_PRESS: begin
          if (!s[i]) begin
            state_d[i] = ST_RELEASED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_PRESSED;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ST_PRESSED: if (!s[i]) state_d[i] = ST_CHK_RELEASE;
        ST_CHK_RELEASE: begin
          if (s[i]) begin
            state_d[i] = ST_PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = ST_RELEASED;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = ST_RELEASED;
      endcase
`ifdef BTN_REPEAT_EN
      // Timer runs only while held; the release-acceptance cycle suppresses any repeat.
      rpt_cnt_d[i] = '0;
      if (REPEAT_MASK[i] && !release_d[i] &&
          (state_q[i] == ST_PRESSED || state_q[i] == ST_CHK_RELEASE)) begin
        rpt_first_d[i] = rpt_first_q[i];
        if (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
          press_d[i]     = 1'b1;
          rpt_first_d[i] = 1'b0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_clk) begin
    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rpt_first_q <= '1;
      for (int i = 0; i < 4; i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_first_q <= rpt_first_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end
`endif

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model checked every cycle, plus directed
// literal expectations for latency, bounce, release, reset and simultaneous presses.
module tb_button_conditioner;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic [3:0] level, press, release_p;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .btn_n_i      (btn_n),
    .btn_level_o  (level),
    .btn_press_o  (press),
    .btn_release_o(release_p)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pin pipeline of depth two, then a run length of samples that disagree with the
  // accepted level; D disagreeing samples in a row flip the level. Repeats follow t = RD + k*RP.
  logic [3:0] m_p1 = 4'hF, m_p2 = 4'hF;
  logic [3:0] m_level = '0, m_press = '0, m_release = '0;
  int         m_run  [4];
  int         m_held [4];
  bit         model_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [3:0] samp;
    cyc++;
    m_press   = '0;
    m_release = '0;
    if (!rst_n) begin
      m_p1 = 4'hF;
      m_p2 = 4'hF;
      m_level = '0;
      for (int i = 0; i < 4; i++) begin
        m_run[i]  = 0;
        m_held[i] = 0;
      end
    end else begin
      samp = ~m_p2;
      m_p2 = m_p1;
      m_p1 = btn_n;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = (samp[i] != m_level[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == D) begin
          m_run[i]   = 0;
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin
            m_press[i] = 1'b1;
            m_held[i]  = 0;
          end else begin
            m_release[i] = 1'b1;
          end
        end else if (m_level[i]) begin
          m_held[i]++;
          if (REP && i < 2 && m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0)
            m_press[i] = 1'b1;
        end
      end
    end
    model_valid = 1'b1;
  end

  int n_press [4];
  int n_rel   [4];
  int last_press [4];
  int last_rel   [4];
  int b1_log [$];

  always @(posedge clk) begin
    #1;
    if (model_valid) begin
      check("level_vs_model", level, m_level);
      check("press_vs_model", press, m_press);
      check("release_vs_model", release_p, m_release);
      check("press_release_overlap", press & release_p, 4'b0000);
      for (int i = 0; i < 4; i++) begin
        if (press[i] === 1'b1) begin
          n_press[i]++;
          last_press[i] = cyc;
          if (i == 1) b1_log.push_back(cyc);
        end
        if (release_p[i] === 1'b1) begin
          n_rel[i]++;
          last_rel[i] = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) begin
      n_press[i] = 0;
      n_rel[i] = 0;
      last_press[i] = -1;
      last_rel[i] = -1;
    end
    b1_log.delete();
  endtask

  initial begin
    int t, t2, r;
    int exp_q [$];
    clear_logs();
    rst_n = 1'b0;
    btn_n = 4'hF;
    tick(3);
    check("reset_level", level, 4'b0000);
    check("reset_press", press, 4'b0000);
    check("reset_release", release_p, 4'b0000);
    rst_n = 1'b1;
    tick(5);

    // Clean press on bit 2: level and single pulse exactly 6 clocks after the pin edge.
    clear_logs();
    t = cyc;
    btn_n[2] = 1'b0;
    tick(5);
    check("clean_press_early", press, 4'b0000);
    check("clean_level_early", level, 4'b0000);
    tick(1);
    check("clean_press_at6", press, 4'b0100);
    check("clean_level_at6", level, 4'b0100);
    tick(1);
    check("clean_press_gone", press, 4'b0000);
    tick(5);
    check_int("clean_press_count", n_press[2], 1);
    check_int("clean_other_press", n_press[0] + n_press[1] + n_press[3], 0);

    // Reset while bit 2 is held and accepted: outputs clear, then one re-qualified press.
    clear_logs();
    r = cyc;
    rst_n = 1'b0;
    tick(1);
    check("midreset_level", level, 4'b0000);
    check("midreset_press", press, 4'b0000);
    check("midreset_release", release_p, 4'b0000);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    check("requal_press", press, 4'b0100);
    check("requal_level", level, 4'b0100);
    tick(4);
    check_int("requal_press_count", n_press[2], 1);
    check_int("requal_press_cycle", last_press[2], r + 8);
    check_int("requal_no_release", n_rel[2], 0);

    clear_logs();
    t = cyc;
    btn_n[2] = 1'b1;
    tick(10);
    check_int("rel2_count", n_rel[2], 1);
    check_int("rel2_cycle", last_rel[2], t + 6);
    check("rel2_level", level, 4'b0000);

    // Bounce on bit 0: low 3, high 1, five times; never 4 stable samples.
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      btn_n[0] = 1'b0;
      tick(3);
      btn_n[0] = 1'b1;
      tick(1);
    end
    tick(10);
    check_int("bounce_press", n_press[0], 0);
    check_int("bounce_release", n_rel[0], 0);
    check("bounce_level", level, 4'b0000);

    // Bit 3 held 30 cycles then released.
    clear_logs();
    t = cyc;
    btn_n[3] = 1'b0;
    tick(30);
    check_int("hold3_press_cycle", last_press[3], t + 6);
    check("hold3_level", level, 4'b1000);
    t2 = cyc;
    btn_n[3] = 1'b1;
    tick(5);
    check("rel3_early", release_p, 4'b0000);
    tick(1);
    check("rel3_at6", release_p, 4'b1000);
    check("rel3_level", level, 4'b0000);
    tick(4);
    check_int("rel3_count", n_rel[3], 1);
    check_int("rel3_cycle", last_rel[3], t2 + 6);

    // Bits 0 and 1 pressed together.
    clear_logs();
    t = cyc;
    btn_n = 4'b1100;
    tick(6);
    check("simul_press", press, 4'b0011);
    tick(6);
    btn_n = 4'hF;
    tick(10);
    check_int("simul_press0", n_press[0], 1);
    check_int("simul_press1", n_press[1], 1);
    check_int("simul_rel0", n_rel[0], 1);

    // Long hold of bits 1 and 2 for 50 cycles.
    clear_logs();
    t = cyc;
    btn_n = 4'b1001;
    tick(50);
    btn_n = 4'hF;
    tick(20);
    exp_q.push_back(t + 6);
    if (REP) begin
      exp_q.push_back(t + 26);
      exp_q.push_back(t + 34);
      exp_q.push_back(t + 42);
      exp_q.push_back(t + 50);
    end
    check_int("hold1_pulse_count", b1_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < b1_log.size()) check_int("hold1_pulse_cycle", b1_log[k], exp_q[k]);
    check_int("hold1_release_cycle", last_rel[1], t + 56);
    check_int("hold2_pulse_count", n_press[2], 1);
    check("hold_final_level", level, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
